// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_pkg : state encoding, coin values and price table for the vend  |
// | controller.                              Rev 1.0                     |
// +----------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_25   = 2'b01;
  localparam logic [1:0] COIN_50   = 2'b10;
  localparam logic [1:0] COIN_100  = 2'b11;

  localparam logic [3:0] UNITS_25  = 4'd1;
  localparam logic [3:0] UNITS_50  = 4'd2;
  localparam logic [3:0] UNITS_100 = 4'd4;

  function automatic logic [3:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_25:  return UNITS_25;
      COIN_50:  return UNITS_50;
      COIN_100: return UNITS_100;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] price(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd3;
      2'd1:    return 4'd4;
      2'd2:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_timer : loadable, clearable 8-bit dispense timeout counter.     |
// |                                          Rev 1.0                     |
// +----------------------------------------------------------------------+
module vend_timer #(
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count;

  // Load outranks clear so the controller can restart the count on VEND entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_controller : coin credit, product vend and change payout FSM.   |
// |                                          Rev 1.0                     |
// +----------------------------------------------------------------------+
module vend_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT    = 200,
  parameter int CREDIT_MAX = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       chg_ack,
  output logic       vend_req,
  output logic [1:0] vend_id,
  output logic       chg_req,
  output logic [3:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       low_credit,
  output logic       vend_fault
);

  state_t     state, state_next;
  logic [3:0] credit_next;
  logic [1:0] vend_id_next;
  logic       coin_reject_next, low_credit_next, vend_fault_next;
  logic       timer_load, timer_expired;
  logic [4:0] coin_sum;

  assign coin_sum = {1'b0, credit} + {1'b0, coin_units(coin)};

  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != ST_VEND),
    .load     (timer_load),
    .load_val (8'd0),
    .en       (state == ST_VEND),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      credit      <= '0;
      vend_id     <= '0;
      coin_reject <= 1'b0;
      low_credit  <= 1'b0;
      vend_fault  <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      vend_id     <= vend_id_next;
      coin_reject <= coin_reject_next;
      low_credit  <= low_credit_next;
      vend_fault  <= vend_fault_next;
    end
  end

  always_comb begin
    state_next       = state;
    credit_next      = credit;
    vend_id_next     = vend_id;
    coin_reject_next = 1'b0;
    low_credit_next  = 1'b0;
    vend_fault_next  = 1'b0;
    timer_load       = 1'b0;

    case (state)
      ST_IDLE: begin
        // A cancel with nothing to refund does not pre-empt sel_valid or coin.
        if (cancel && (credit != 4'd0)) begin
          state_next       = ST_CHANGE;
          coin_reject_next = (coin != COIN_NONE);
        end else if (sel_valid) begin
          coin_reject_next = (coin != COIN_NONE);
          if (credit >= price(sel)) begin
            credit_next  = credit - price(sel);
            vend_id_next = sel;
            state_next   = ST_VEND;
            timer_load   = 1'b1;
          end else begin
            low_credit_next = 1'b1;
          end
        end else if (coin != COIN_NONE) begin
          if (coin_sum <= 5'(CREDIT_MAX)) begin
            credit_next = coin_sum[3:0];
          end else begin
            coin_reject_next = 1'b1;
          end
        end
      end

      ST_VEND: begin
        coin_reject_next = (coin != COIN_NONE);
        if (vend_ack) begin
          state_next = (credit != 4'd0) ? ST_CHANGE : ST_IDLE;
        end else if (timer_expired) begin
          vend_fault_next = 1'b1;
          credit_next     = credit + price(vend_id);
          state_next      = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        coin_reject_next = (coin != COIN_NONE);
        if (credit == 4'd0) begin
          state_next = ST_IDLE;
        end else if (chg_ack) begin
          credit_next = credit - 4'd1;
          if (credit == 4'd1) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign vend_req = (state == ST_VEND);
  assign chg_req  = (state == ST_CHANGE) && (credit != 4'd0);
  assign busy     = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vend_controller : scoreboard bench with a behavioural reference.  |
// |                                          Rev 1.0                     |
// +----------------------------------------------------------------------+
module tb_vend_controller;

  localparam int TIMEOUT    = 20;
  localparam int CREDIT_MAX = 12;
  localparam int N_RANDOM   = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin = 2'd0;
  logic [1:0] sel = 2'd0;
  logic       sel_valid = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       vend_req, chg_req, busy, coin_reject, low_credit, vend_fault;
  logic [1:0] vend_id;
  logic [3:0] credit;

  vend_controller #(.TIMEOUT(TIMEOUT), .CREDIT_MAX(CREDIT_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .cancel      (cancel),
    .vend_ack    (vend_ack),
    .chg_ack     (chg_ack),
    .vend_req    (vend_req),
    .vend_id     (vend_id),
    .chg_req     (chg_req),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .low_credit  (low_credit),
    .vend_fault  (vend_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vend_req;
    int vend_id;
    bit chg_req;
    int credit;
    bit busy;
    bit reject;
    bit low;
    bit fault;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: the machine is either taking money, dispensing, or paying out.
  int   PRICE[4] = '{3, 4, 6, 8};
  int   VALUE[4] = '{0, 1, 2, 4};
  int   m_credit, m_item, m_waited;
  bit   m_vending, m_refunding;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_item = 0; m_waited = 0;
    m_vending = 0; m_refunding = 0;
  endtask

  task automatic model_step(output exp_t e);
    int c;
    c = VALUE[coin];
    e.reject = 0; e.low = 0; e.fault = 0;
    if (m_vending) begin
      e.reject = (c != 0);
      if (vend_ack) begin
        m_vending   = 0;
        m_refunding = (m_credit > 0);
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          e.fault     = 1;
          m_credit    = m_credit + PRICE[m_item];
          m_vending   = 0;
          m_refunding = 1;
        end
      end
    end else if (m_refunding) begin
      e.reject = (c != 0);
      if (chg_ack && m_credit > 0) begin
        m_credit--;
        if (m_credit == 0) m_refunding = 0;
      end
    end else begin
      if (cancel && m_credit > 0) begin
        m_refunding = 1;
        e.reject    = (c != 0);
      end else if (sel_valid) begin
        e.reject = (c != 0);
        if (m_credit >= PRICE[sel]) begin
          m_credit  = m_credit - PRICE[sel];
          m_item    = int'(sel);
          m_vending = 1;
          m_waited  = 0;
        end else begin
          e.low = 1;
        end
      end else if (c != 0) begin
        if (m_credit + c <= CREDIT_MAX) m_credit = m_credit + c;
        else e.reject = 1;
      end
    end
    e.credit   = m_credit;
    e.vend_req = m_vending;
    e.vend_id  = m_item;
    e.chg_req  = m_refunding && (m_credit > 0);
    e.busy     = m_vending || m_refunding;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic cyc(input logic [1:0] c, input logic [1:0] s, input logic sv,
                     input logic cn, input logic va, input logic ca);
    exp_t e;
    @(negedge clk);
    coin = c; sel = s; sel_valid = sv; cancel = cn; vend_ack = va; chg_ack = ca;
    model_step(e);
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    coin = 2'd0; sel = 2'd0; sel_valid = 1'b0; cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;
    #2;
    chk({tag, "_vend_req"}, int'(vend_req), 0);
    chk({tag, "_vend_id"}, int'(vend_id), 0);
    chk({tag, "_chg_req"}, int'(chg_req), 0);
    chk({tag, "_credit"}, int'(credit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_coin_reject"}, int'(coin_reject), 0);
    chk({tag, "_low_credit"}, int'(low_credit), 0);
    chk({tag, "_vend_fault"}, int'(vend_fault), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_vend_req", int'(vend_req), int'(e.vend_req));
      if (e.vend_req) chk("sb_vend_id", int'(vend_id), e.vend_id);
      chk("sb_chg_req", int'(chg_req), int'(e.chg_req));
      chk("sb_credit", int'(credit), e.credit);
      chk("sb_busy", int'(busy), int'(e.busy));
      chk("sb_coin_reject", int'(coin_reject), int'(e.reject));
      chk("sb_low_credit", int'(low_credit), int'(e.low));
      chk("sb_vend_fault", int'(vend_fault), int'(e.fault));
    end
  end

  initial begin
    int  waited;
    bit  seen;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("rst_init");

    // Exact-change purchase.
    cyc(2'b10, 0, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0, 0); settle(); chk("d36_credit", int'(credit), 3);
    cyc(0, 2'd0, 1, 0, 0, 0);  settle();
    chk("d36_vend_req", int'(vend_req), 1);
    chk("d36_vend_id", int'(vend_id), 0);
    chk("d36_credit0", int'(credit), 0);
    cyc(0, 0, 0, 0, 1, 0);     settle();
    chk("d36_idle", int'(busy), 0);
    chk("d36_no_chg", int'(chg_req), 0);

    // Purchase with change.
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0); settle(); chk("d37_credit8", int'(credit), 8);
    cyc(0, 2'd2, 1, 0, 0, 0);  settle(); chk("d37_credit2", int'(credit), 2);
    cyc(0, 0, 0, 0, 1, 0);     settle(); chk("d37_chg_req", int'(chg_req), 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);     settle();
    chk("d37_credit0", int'(credit), 0);
    chk("d37_idle", int'(busy), 0);

    // Credit ceiling and coins while busy.
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0, 0); settle(); chk("d38_credit11", int'(credit), 11);
    cyc(2'b10, 0, 0, 0, 0, 0); settle();
    chk("d38_reject", int'(coin_reject), 1);
    chk("d38_credit_kept", int'(credit), 11);
    cyc(0, 2'd3, 1, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0, 0); settle();
    chk("d38_vend_reject", int'(coin_reject), 1);
    chk("d38_vend_credit", int'(credit), 3);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

    // Refused selection, then refund.
    cyc(2'b10, 0, 0, 0, 0, 0);
    cyc(0, 2'd1, 1, 0, 0, 0);  settle();
    chk("d39_low_credit", int'(low_credit), 1);
    chk("d39_idle", int'(busy), 0);
    cyc(0, 0, 0, 1, 0, 0);     settle(); chk("d39_chg_req", int'(chg_req), 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);     settle(); chk("d39_done", int'(busy), 0);

    // Dispense timeout.
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(0, 2'd1, 1, 0, 0, 0);
    seen = 0; waited = 0;
    for (int i = 0; i < TIMEOUT + 10 && !seen; i++) begin
      idle(); settle();
      waited = i + 1;
      if (vend_fault) seen = 1;
    end
    chk("d40_fault_seen", int'(seen), 1);
    chk("d40_fault_latency", waited, TIMEOUT);
    chk("d40_credit", int'(credit), 4);
    chk("d40_chg_req", int'(chg_req), 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);

    // Reset mid-vend, then same-cycle priority.
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0, 0);
    cyc(0, 2'd0, 1, 0, 0, 0);  settle(); chk("d41_vend_credit", int'(credit), 2);
    do_reset("d41_rst");
    cyc(2'b01, 0, 0, 0, 0, 0);
    cyc(2'b01, 2'd0, 1, 1, 0, 0); settle();
    chk("d41_cancel_wins", int'(chg_req), 1);
    chk("d41_coin_rejected", int'(coin_reject), 1);
    chk("d41_no_low", int'(low_credit), 0);
    chk("d41_no_vend", int'(vend_req), 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < N_RANDOM; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc(($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 35));
      end
    end
    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
